// File: rtl/cmp_serial.sv
// Serial MSB-first magnitude comparator: STEP bits per clock, unsigned or two's-complement.
// Optional early completion on the first differing digit: define CMP_SERIAL_EARLY_EXIT_EN.
module cmp_serial #(
   parameter int WIDTH = 16,
   parameter int STEP  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sgn,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             eq,
   output logic             lt
);

   localparam int N  = WIDTH / STEP;
   localparam int CW = $clog2(N + 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] sa_reg;
   logic [WIDTH-1:0] sb_reg;
   logic [CW-1:0]    cnt_reg;
   logic             gt_acc_reg;
   logic             eq_acc_reg;
   logic             lt_acc_reg;

   logic [STEP-1:0]  da;
   logic [STEP-1:0]  db;
   logic [STEP-1:0]  cell_gt;
   logic [STEP-1:0]  cell_eq;
   logic [STEP-1:0]  cell_lt;
   logic             dgt;
   logic             deq;
   logic             dlt;
   logic             gt_acc_next;
   logic             eq_acc_next;
   logic             lt_acc_next;
   logic             last_digit;
   logic             finish;
   logic [WIDTH-1:0] sign_mask;

   // Flipping the MSB maps two's-complement onto offset binary, so the datapath stays unsigned.
   assign sign_mask = {sgn, {(WIDTH-1){1'b0}}};

   assign da = sa_reg[WIDTH-1 -: STEP];
   assign db = sb_reg[WIDTH-1 -: STEP];

   genvar gi;
   generate
      for (gi = 0; gi < STEP; gi++) begin : g_cell
         assign cell_gt[gi] = da[gi] & ~db[gi];
         assign cell_eq[gi] = ~(da[gi] ^ db[gi]);
         assign cell_lt[gi] = ~da[gi] & db[gi];
      end
   endgenerate

   // Combiner chain across the digit, most significant cell first.
   always_comb begin
      dgt = 1'b0;
      deq = 1'b1;
      dlt = 1'b0;
      for (int i = STEP - 1; i >= 0; i--) begin
         dgt = dgt | (deq & cell_gt[i]);
         dlt = dlt | (deq & cell_lt[i]);
         deq = deq & cell_eq[i];
      end
   end

   assign gt_acc_next = gt_acc_reg | (eq_acc_reg & dgt);
   assign lt_acc_next = lt_acc_reg | (eq_acc_reg & dlt);
   assign eq_acc_next = eq_acc_reg & deq;
   assign last_digit  = (cnt_reg == CW'(1));

`ifdef CMP_SERIAL_EARLY_EXIT_EN
   assign finish = last_digit | gt_acc_next | lt_acc_next;
`else
   assign finish = last_digit;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         sa_reg     <= '0;
         sb_reg     <= '0;
         cnt_reg    <= '0;
         gt_acc_reg <= 1'b0;
         eq_acc_reg <= 1'b0;
         lt_acc_reg <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         gt         <= 1'b0;
         eq         <= 1'b0;
         lt         <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sa_reg     <= a ^ sign_mask;
                  sb_reg     <= b ^ sign_mask;
                  gt_acc_reg <= 1'b0;
                  eq_acc_reg <= 1'b1;
                  lt_acc_reg <= 1'b0;
                  cnt_reg    <= CW'(N);
                  busy       <= 1'b1;
                  state_reg  <= RUN;
               end
            end
            RUN: begin
               gt_acc_reg <= gt_acc_next;
               eq_acc_reg <= eq_acc_next;
               lt_acc_reg <= lt_acc_next;
               sa_reg     <= sa_reg << STEP;
               sb_reg     <= sb_reg << STEP;
               cnt_reg    <= cnt_reg - CW'(1);
               if (finish) begin
                  // Publish from the next-state terms so the last digit is included.
                  gt        <= gt_acc_next;
                  eq        <= eq_acc_next;
                  lt        <= lt_acc_next;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
               busy      <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmp_serial.sv
// Directed bench for cmp_serial (WIDTH=16, STEP=2); expected latencies follow CMP_SERIAL_EARLY_EXIT_EN.
module tb_cmp_serial;

   localparam int N = 8;
`ifdef CMP_SERIAL_EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        sgn;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic        gt;
   logic        eq;
   logic        lt;

   int n_checks = 0;
   int n_fail   = 0;
   int lat;

   cmp_serial #(.WIDTH(16), .STEP(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .sgn   (sgn),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .gt    (gt),
      .eq    (eq),
      .lt    (lt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
      n_checks++;
      if (obs !== exp_val) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_val);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   // j = 1-based index of first differing digit (hand computed per vector)
   function automatic int lat_for(input int j);
      return EE ? j : N;
   endfunction

   task automatic apply_start(input logic [15:0] av, input logic [15:0] bv, input logic sv);
      @(negedge clk);
      a     = av;
      b     = bv;
      sgn   = sv;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = 16'hDEAD;
      b     = 16'hBEEF;
      sgn   = 1'b0;
   endtask

   task automatic wait_done(input int base, output int cycles);
      cycles = base;
      while (done !== 1'b1 && cycles < 40) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      sgn   = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_res",  32'({gt, eq, lt}), 32'b000);
      @(negedge clk);
      rst_n = 1'b1;

      // equal operands
      apply_start(16'h1234, 16'h1234, 1'b0);
      check("eq_busy", 32'(busy), 32'd1);
      wait_done(0, lat);
      check("eq_lat", 32'(lat), 32'(lat_for(N)));
      check("eq_res", 32'({gt, eq, lt}), 32'b010);
      check("eq_busy_done", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      check("eq_done_pulse", 32'(done), 32'd0);

      // unsigned 0x8000 > 0x7FFF; result from previous op held while running
      apply_start(16'h8000, 16'h7FFF, 1'b0);
      check("hold_prev", 32'({gt, eq, lt}), 32'b010);
      wait_done(0, lat);
      check("uns_lat", 32'(lat), 32'(lat_for(1)));
      check("uns_res", 32'({gt, eq, lt}), 32'b100);

      // signed -32768 < 32767
      apply_start(16'h8000, 16'h7FFF, 1'b1);
      wait_done(0, lat);
      check("sgn_lat", 32'(lat), 32'(lat_for(1)));
      check("sgn_res", 32'({gt, eq, lt}), 32'b001);

      // early exit vector
      apply_start(16'h4000, 16'h0000, 1'b0);
      wait_done(0, lat);
      check("ee_lat", 32'(lat), 32'(lat_for(1)));
      check("ee_res", 32'({gt, eq, lt}), 32'b100);

      // start while busy is ignored
      apply_start(16'd5, 16'd9, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1;
      a     = 16'd9;
      b     = 16'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(3, lat);
      check("busy_ign_lat", 32'(lat), 32'(lat_for(7)));
      check("busy_ign_res", 32'({gt, eq, lt}), 32'b001);

      // back-to-back start in the done cycle: -1 < 1
      apply_start(16'hFFFF, 16'h0001, 1'b1);
      check("b2b_busy", 32'(busy), 32'd1);
      check("b2b_done_low", 32'(done), 32'd0);
      wait_done(0, lat);
      check("b2b_lat", 32'(lat), 32'(lat_for(1)));
      check("b2b_res", 32'({gt, eq, lt}), 32'b001);

      // asynchronous reset mid-run
      apply_start(16'd3, 16'd1, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_res",  32'({gt, eq, lt}), 32'b000);
      repeat (6) @(posedge clk);
      #1;
      check("mid_rst_nodone", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      apply_start(16'd3, 16'd1, 1'b0);
      wait_done(0, lat);
      check("post_rst_lat", 32'(lat), 32'(lat_for(8)));
      check("post_rst_res", 32'({gt, eq, lt}), 32'b100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
